// File: rtl/spi_master.sv
// spi_master: command-driven SPI master for an SPI slave/RAM block.
// Each accepted command becomes one slave-select frame made of an 11-bit
// header, MSB first. A read-data command then idles for RD_WAIT cycles and
// shifts one byte in from miso before the frame closes.
module spi_master #(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_code,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
        $error("spi_master: RD_WAIT must be within 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_END
    } state_t;

    // Counter reload values. Each count runs down to zero inside its state,
    // so the 4-bit counter never wraps.
    localparam logic [3:0] SEND_LOAD = 4'd10;
    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] RECV_LOAD = 4'd7;

    state_t      state_q;
    logic [10:0] shift_q;     // header being sent; bit 9 is the next mosi bit
    logic [6:0]  rx_q;        // miso bits collected so far
    logic [3:0]  cnt_q;       // bits or wait cycles left in the current state
    logic        is_rd_q;     // the current frame is a read-data frame
    logic        ss_n_q;
    logic        mosi_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;

    // Frame sequencer: one registered FSM that also produces every SPI output.
    // NOTE: state registers use non-blocking assignments so that every branch reads the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            is_rd_q     <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // The header is captured here, so later changes on
                        // the command inputs cannot reach the frame.
                        shift_q <= {cmd_code[1], cmd_code, cmd_data};
                        mosi_q  <= cmd_code[1];
                        is_rd_q <= &cmd_code;
                        cnt_q   <= SEND_LOAD;
                        ss_n_q  <= 1'b0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cnt_q == 4'd0) begin
                        mosi_q <= 1'b0;
                        if (is_rd_q) begin
                            cnt_q   <= WAIT_LOAD;
                            state_q <= S_WAIT;
                        end else begin
                            cnt_q   <= 4'd0;
                            ss_n_q  <= 1'b1;
                            state_q <= S_END;
                        end
                    end else begin
                        shift_q <= shift_q << 1;
                        mosi_q  <= shift_q[9];
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q   <= RECV_LOAD;
                        state_q <= S_RECV;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RECV: begin
                    rx_q <= {rx_q[5:0], miso};
                    if (cnt_q == 4'd0) begin
                        rsp_data_q  <= {rx_q, miso};
                        rsp_valid_q <= 1'b1;
                        ss_n_q      <= 1'b1;
                        cnt_q       <= 4'd0;
                        state_q     <= S_END;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_END: begin
                    // One cycle with ss_n high guarantees a gap between frames.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign ss_n      = ss_n_q;
    assign mosi      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
